beat_scheduler: RTL

- Tempo controller for the game's song playback.
- Wraps a programmable down-counter of the rate-divider kind and sequences it through start, pause, stop and end-of-song.
- Emits one beat_tick per beat period and the chart index of that beat; the note-chart ROM and scoring logic consume both.
- Tempo is selectable among four periods and changes only on a beat boundary, so no beat is ever truncated.

---
 rtl/beat_scheduler.sv | 105 ++++++++++
 1 files changed

// File: rtl/beat_scheduler.sv
// Song tempo controller: a reloading down-counter that emits one beat
// tick per period and the chart index of that beat.
module beat_scheduler #(
    parameter int unsigned CNT_W    = 28,
    parameter int unsigned PERIOD_0 = 833333,
    parameter int unsigned PERIOD_1 = 50000000,
    parameter int unsigned PERIOD_2 = 100000000,
    parameter int unsigned PERIOD_3 = 200000000,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned SONG_LEN = 200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [1:0]        tempo_sel,
    output logic              beat_tick,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              running,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] RELOAD_0 = CNT_W'(PERIOD_0 - 1);
    localparam logic [CNT_W-1:0] RELOAD_1 = CNT_W'(PERIOD_1 - 1);
    localparam logic [CNT_W-1:0] RELOAD_2 = CNT_W'(PERIOD_2 - 1);
    localparam logic [CNT_W-1:0] RELOAD_3 = CNT_W'(PERIOD_3 - 1);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  reload;
    logic [ADDR_W-1:0] next_idx;

    logic active;
    logic can_start;
    logic advance;
    logic expire;
    logic last_beat;

    always_comb begin
        unique case (tempo_sel)
            2'b00:   reload = RELOAD_0;
            2'b01:   reload = RELOAD_1;
            2'b10:   reload = RELOAD_2;
            default: reload = RELOAD_3;
        endcase
    end

    assign active    = (state == S_RUN) || (state == S_PAUSE);
    assign can_start = start && ((state == S_IDLE) || (state == S_DONE));
    // Leaving PAUSE counts as a running cycle, so paused edges are the
    // only ones that do not advance the beat.
    assign advance   = active && !pause;
    assign expire    = advance && (count == '0);
    assign last_beat = (next_idx == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            next_idx  <= '0;
            beat_tick <= 1'b0;
            beat_addr <= '0;
        end else begin
            beat_tick <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                count     <= '0;
                next_idx  <= '0;
                beat_addr <= '0;
            end else if (can_start) begin
                state     <= S_RUN;
                count     <= reload;
                next_idx  <= '0;
                beat_addr <= '0;
            end else if (active && pause) begin
                state <= S_PAUSE;
            end else if (expire) begin
                beat_tick <= 1'b1;
                beat_addr <= next_idx;
                count     <= reload;
                if (last_beat) begin
                    state <= S_DONE;
                end else begin
                    state    <= S_RUN;
                    next_idx <= next_idx + ADDR_W'(1);
                end
            end else if (advance) begin
                state <= S_RUN;
                count <= count - CNT_W'(1);
            end
        end
    end

    assign running = active;
    assign done    = (state == S_DONE);

endmodule
